// File: rtl/prog_run_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prog_run_ctrl_if                                                 |
// | Purpose  : Bundles the harness/processor handshake of the run sequencer.    |
// |            master = sequencer side, slave = harness / processor side.       |
// | Signals  : Go, DutAck (to sequencer); DutReset, DutStart, ProgSel, Busy,    |
// |            Done, CycleCt, CtValid, Timeout, ErrMask (from sequencer).       |
// |            With RUN_LOG_EN defined: LogAddr (to), LogData (from).           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface prog_run_ctrl_if #(
   parameter int NUM_PROGS = 3,
   parameter int CT_W      = 16
);
   localparam int PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

   logic                 Go;
   logic                 DutAck;
   logic                 DutReset;
   logic                 DutStart;
   logic [PW-1:0]        ProgSel;
   logic                 Busy;
   logic                 Done;
   logic [CT_W-1:0]      CycleCt;
   logic                 CtValid;
   logic                 Timeout;
   logic [NUM_PROGS-1:0] ErrMask;
`ifdef RUN_LOG_EN
   logic [PW-1:0]        LogAddr;
   logic [CT_W-1:0]      LogData;

   modport master (
      input  Go, DutAck, LogAddr,
      output DutReset, DutStart, ProgSel, Busy, Done,
             CycleCt, CtValid, Timeout, ErrMask, LogData
   );
   modport slave (
      output Go, DutAck, LogAddr,
      input  DutReset, DutStart, ProgSel, Busy, Done,
             CycleCt, CtValid, Timeout, ErrMask, LogData
   );
`else
   modport master (
      input  Go, DutAck,
      output DutReset, DutStart, ProgSel, Busy, Done,
             CycleCt, CtValid, Timeout, ErrMask
   );
   modport slave (
      output Go, DutAck,
      input  DutReset, DutStart, ProgSel, Busy, Done,
             CycleCt, CtValid, Timeout, ErrMask
   );
`endif
endinterface
`default_nettype wire

// File: rtl/prog_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prog_run_ctrl                                                    |
// | Purpose  : Run sequencer in front of the processor. On Go it resets the     |
// |            processor once, then runs NUM_PROGS programs back to back        |
// |            (Start pulse, wait for Ack), measuring each program's RUN cycle  |
// |            count and flagging programs that hit the watchdog limit.         |
// | Ports    : Clk   - clock, rising edge                                       |
// |            Reset - synchronous, active-high                                 |
// |            bus   - prog_run_ctrl_if.master (Go/DutAck in; DutReset,         |
// |                    DutStart, ProgSel, Busy, Done, CycleCt, CtValid,         |
// |                    Timeout, ErrMask out; LogAddr/LogData when logging)      |
// | Options  : RUN_LOG_EN - per-program count log readable via LogAddr/LogData  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module prog_run_ctrl #(
   parameter int          NUM_PROGS    = 3,
   parameter int          CT_W         = 16,
   parameter int unsigned TIMEOUT      = 32'h0000_FFFF,
   parameter int          START_CYCLES = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   prog_run_ctrl_if.master  bus
);

   localparam int PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
   localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

   localparam logic [CT_W-1:0] c_timeout   = CT_W'(TIMEOUT);
   localparam logic [PW-1:0]   c_lastProg  = PW'(NUM_PROGS - 1);
   localparam logic [SW-1:0]   c_startLast = SW'(START_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RST   = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_REC   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic                 w_goAccept;

   logic [SW-1:0]        r_startCt;
   logic [CT_W-1:0]      r_runCt;
   logic                 r_toMark;      // current program ended on the watchdog

   logic                 r_rstQ;
   logic                 r_dutStart;
   logic [PW-1:0]        r_progSel;
   logic                 r_busy;
   logic                 r_done;
   logic [CT_W-1:0]      r_cycleCt;
   logic                 r_ctValid;
   logic                 r_timeout;
   logic [NUM_PROGS-1:0] r_errMask;

   logic [CT_W-1:0]      w_ctInc;
   logic                 w_hitTimeout;
   logic [NUM_PROGS-1:0] w_selMask;     // one-hot of the current program

   // Saturating increment: the counter never passes the watchdog limit.
   assign w_ctInc      = (r_runCt >= c_timeout) ? c_timeout : r_runCt + 1'b1;
   // An Ack in the same cycle wins over the watchdog.
   assign w_hitTimeout = !bus.DutAck && (w_ctInc == c_timeout);

   generate
      for (genvar i = 0; i < NUM_PROGS; i++) begin : g_selMask
         assign w_selMask[i] = (r_progSel == PW'(i));
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_nextState = r_state;
      w_goAccept  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.Go) begin
               w_nextState = S_RST;
               w_goAccept  = 1'b1;
            end
         end
         S_RST: begin
            w_nextState = S_START;
         end
         S_START: begin
            // DutAck deliberately ignored: it may still be high from the last halt.
            if (r_startCt == c_startLast) begin
               w_nextState = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.DutAck || w_hitTimeout) begin
               w_nextState = S_REC;
            end
         end
         S_REC: begin
            if (r_progSel == c_lastProg) begin
               w_nextState = S_DONE;
            end else begin
               w_nextState = S_START;
            end
         end
         S_DONE: begin
            if (bus.Go) begin
               w_nextState = S_RST;
               w_goAccept  = 1'b1;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register and registered outputs. Level outputs are computed from
   // the next state so they line up exactly with the state they describe.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_startCt  <= '0;
         r_runCt    <= '0;
         r_toMark   <= 1'b0;
         r_rstQ     <= 1'b0;
         r_dutStart <= 1'b0;
         r_progSel  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cycleCt  <= '0;
         r_ctValid  <= 1'b0;
         r_timeout  <= 1'b0;
         r_errMask  <= '0;
      end else begin
         r_state    <= w_nextState;
         r_rstQ     <= (w_nextState == S_RST);
         r_dutStart <= (w_nextState == S_START);
         r_busy     <= (w_nextState != S_IDLE) && (w_nextState != S_DONE);
         r_done     <= (w_nextState == S_DONE);
         r_ctValid  <= (r_state == S_REC);

         // START length counter, idle at zero outside START.
         if (r_state == S_START) begin
            r_startCt <= r_startCt + 1'b1;
         end else begin
            r_startCt <= '0;
         end

         case (r_state)
            S_START: begin
               r_runCt  <= '0;
               r_toMark <= 1'b0;
            end
            S_RUN: begin
               if (!bus.DutAck) begin
                  r_runCt  <= w_ctInc;
                  r_toMark <= w_hitTimeout;
               end
            end
            S_REC: begin
               r_cycleCt <= r_runCt;
               if (r_toMark) begin
                  r_errMask <= r_errMask | w_selMask;
                  r_timeout <= 1'b1;
               end
               if (r_progSel != c_lastProg) begin
                  r_progSel <= r_progSel + 1'b1;
               end
            end
            default: begin
            end
         endcase

         if (w_goAccept) begin
            r_timeout <= 1'b0;
            r_errMask <= '0;
            r_progSel <= '0;
         end
      end
   end

   assign bus.DutReset = Reset | r_rstQ;
   assign bus.DutStart = r_dutStart;
   assign bus.ProgSel  = r_progSel;
   assign bus.Busy     = r_busy;
   assign bus.Done     = r_done;
   assign bus.CycleCt  = r_cycleCt;
   assign bus.CtValid  = r_ctValid;
   assign bus.Timeout  = r_timeout;
   assign bus.ErrMask  = r_errMask;

`ifdef RUN_LOG_EN
   // ------------------------------------------------------------------------
   // Per-program count log, written in REC, cleared on Reset and accepted Go.
   // ------------------------------------------------------------------------
   logic [CT_W-1:0] r_log [NUM_PROGS];
   logic [CT_W-1:0] w_logData;

   always_ff @(posedge Clk) begin
      if (Reset || w_goAccept) begin
         for (int i = 0; i < NUM_PROGS; i++) begin
            r_log[i] <= '0;
         end
      end else if (r_state == S_REC) begin
         for (int i = 0; i < NUM_PROGS; i++) begin
            if (w_selMask[i]) begin
               r_log[i] <= r_runCt;
            end
         end
      end
   end

   // Address decode leaves out-of-range addresses reading zero.
   always_comb begin
      w_logData = '0;
      for (int i = 0; i < NUM_PROGS; i++) begin
         if (bus.LogAddr == PW'(i)) begin
            w_logData = r_log[i];
         end
      end
   end

   assign bus.LogData = w_logData;
`else
   // No log: only the most recent count is observable on CycleCt.
`endif

endmodule
`default_nettype wire
